// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, CON bit positions and engine state encodings shared by the UART controller
package uart_pkg;
  localparam logic [31:0] OFS_TXD = 32'd0;
  localparam logic [31:0] OFS_RXD = 32'd4;
  localparam logic [31:0] OFS_CON = 32'd8;
  localparam int CON_TX_IE   = 0;
  localparam int CON_RX_IE   = 1;
  localparam int CON_TX_DONE = 2;
  localparam int CON_RX_DONE = 3;
  localparam int CON_TX_BUSY = 4;
  localparam int CON_RX_OVR  = 5;
  localparam int CON_RX_FE   = 6;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_e;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receive engine with 2-flop input synchroniser, mid-bit sampling and stop-bit framing check
module uart_rx import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rxd_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       fe_o
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] MID  = W'(CLKS_PER_BIT / 2 - 1);
  rx_state_e state_q;
  logic [1:0] sync_q;
  logic [W-1:0] cnt_q;
  logic [2:0] idx_q;
  logic [7:0] sh_q;
  logic rxs, tick;
  assign rxs = sync_q[1];
  assign tick = cnt_q == LAST;
  assign byte_o = sh_q;
  assign valid_o = state_q == RX_STOP && tick && rxs;
  assign fe_o = state_q == RX_STOP && tick && !rxs;
  // the idle cycle that detects the falling edge counts as the first cycle of the half-bit wait
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
    end else begin
      sync_q <= {sync_q[0], rxd_i};
      case (state_q)
        RX_IDLE: if (!rxs) begin
          state_q <= RX_START;
          cnt_q   <= W'(1);
        end
        RX_START: if (cnt_q == MID) begin
          state_q <= rxs ? RX_IDLE : RX_DATA;
          cnt_q   <= '0;
          idx_q   <= '0;
        end else cnt_q <= cnt_q + 1'b1;
        RX_DATA: if (tick) begin
          cnt_q <= '0;
          sh_q  <= {rxs, sh_q[7:1]};
          idx_q <= idx_q + 3'd1;
          if (idx_q == 3'd7) state_q <= RX_STOP;
        end else cnt_q <= cnt_q + 1'b1;
        RX_STOP: if (tick) begin
          cnt_q   <= '0;
          state_q <= rxs ? RX_IDLE : RX_WAIT_HIGH;
        end else cnt_q <= cnt_q + 1'b1;
        RX_WAIT_HIGH: if (rxs) state_q <= RX_IDLE;
        default: state_q <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/uart_ctrl.sv
// uart_ctrl: memory-mapped 8N1 UART with TXD/RXD/CON registers, inline TX engine and level interrupt
module uart_ctrl import uart_pkg::*; #(
  parameter int          CLKS_PER_BIT = 5208,
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0018
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rxd,
  output logic        txd,
  output logic        irq
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  tx_state_e tx_state_q;
  logic [W-1:0] tx_cnt_q;
  logic [2:0] tx_idx_q;
  logic [7:0] txd_data_q, rxd_data_q, rx_byte;
  logic txd_q, irq_q, tx_ie_q, rx_ie_q, tx_done_q, rx_done_q, rx_ovr_q, rx_fe_q;
  logic sel_txd, sel_rxd, sel_con, con_rd, txd_wr, tx_done_set, tx_busy, rx_valid, rx_fe;
  logic [6:0] con;
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];
  assign sel_txd = addr == BASE_ADDR + OFS_TXD;
  assign sel_rxd = addr == BASE_ADDR + OFS_RXD;
  assign sel_con = addr == BASE_ADDR + OFS_CON;
  assign con_rd = rd && sel_con;
  assign tx_busy = tx_state_q != TX_IDLE;
  assign txd_wr = wr && sel_txd && !tx_busy;
  assign tx_done_set = tx_state_q == TX_STOP && tx_cnt_q == LAST;
  assign txd = txd_q;
  assign irq = irq_q;
  always_comb begin
    con = '0;
    con[CON_TX_IE]   = tx_ie_q;
    con[CON_RX_IE]   = rx_ie_q;
    con[CON_TX_DONE] = tx_done_q;
    con[CON_RX_DONE] = rx_done_q;
    con[CON_TX_BUSY] = tx_busy;
    con[CON_RX_OVR]  = rx_ovr_q;
    con[CON_RX_FE]   = rx_fe_q;
    rdata = !rd ? '0 : sel_txd ? {24'd0, txd_data_q} : sel_rxd ? {24'd0, rxd_data_q} :
            sel_con ? {25'd0, con} : '0;
  end
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      txd_q      <= 1'b1;
      txd_data_q <= '0;
    end else begin
      case (tx_state_q)
        TX_IDLE: if (txd_wr) begin
          txd_data_q <= wdata[7:0];
          tx_state_q <= TX_START;
          tx_cnt_q   <= '0;
          txd_q      <= 1'b0;
        end
        TX_START: if (tx_cnt_q == LAST) begin
          tx_cnt_q   <= '0;
          tx_idx_q   <= '0;
          tx_state_q <= TX_DATA;
          txd_q      <= txd_data_q[0];
        end else tx_cnt_q <= tx_cnt_q + 1'b1;
        TX_DATA: if (tx_cnt_q == LAST) begin
          tx_cnt_q   <= '0;
          tx_idx_q   <= tx_idx_q + 3'd1;
          tx_state_q <= tx_idx_q == 3'd7 ? TX_STOP : TX_DATA;
          txd_q      <= tx_idx_q == 3'd7 ? 1'b1 : txd_data_q[tx_idx_q + 3'd1];
        end else tx_cnt_q <= tx_cnt_q + 1'b1;
        TX_STOP: if (tx_cnt_q == LAST) begin
          tx_cnt_q   <= '0;
          tx_state_q <= TX_IDLE;
        end else tx_cnt_q <= tx_cnt_q + 1'b1;
      endcase
    end
  end
  // status bits: a set in the same cycle as a CON read clear takes priority
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      {tx_ie_q, rx_ie_q, tx_done_q, rx_done_q, rx_ovr_q, rx_fe_q, irq_q} <= '0;
      rxd_data_q <= '0;
    end else begin
      if (wr && sel_con) {rx_ie_q, tx_ie_q} <= wdata[1:0];
      tx_done_q <= tx_done_set | (tx_done_q & ~con_rd);
      rx_done_q <= rx_valid | (rx_done_q & ~con_rd);
      rx_ovr_q  <= (rx_valid & rx_done_q) | (rx_ovr_q & ~con_rd);
      rx_fe_q   <= rx_fe | (rx_fe_q & ~con_rd);
      if (rx_valid) rxd_data_q <= rx_byte;
      irq_q <= (tx_ie_q & tx_done_q) | (rx_ie_q & rx_done_q);
    end
  end
  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i  (sysclk),
    .rst_i  (reset),
    .rxd_i  (rxd),
    .byte_o (rx_byte),
    .valid_o(rx_valid),
    .fe_o   (rx_fe)
  );
endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: directed and randomized checks of uart_ctrl against a frame-level behavioural model
module tb_uart_ctrl;
  localparam int CPB = 16;
  localparam int P = 20;
  localparam int BIT = CPB * P;
  localparam logic [31:0] BASE = 32'h4000_0018;
  localparam logic [31:0] A_TXD = BASE, A_RXD = BASE + 4, A_CON = BASE + 8;
  logic clk, rst, rd, wr, rxd, txd, irq, txd_d, irq_d;
  logic [31:0] addr, wdata, rdata, rdata_d, d;
  int n_cmp = 0, n_bad = 0;
  logic m_tx_ie, m_rx_ie, m_txdone, m_rxdone, m_ovr, m_fe;
  logic [7:0] m_rxd, b0, b1, b2;
  int n;

  uart_ctrl #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE)) dut (
    .sysclk(clk), .reset(rst), .addr(addr), .rd(rd), .wr(wr), .wdata(wdata),
    .rdata(rdata), .rxd(rxd), .txd(txd), .irq(irq));
  uart_ctrl dut_def (
    .sysclk(clk), .reset(rst), .addr(addr), .rd(rd), .wr(wr), .wdata(wdata),
    .rdata(rdata_d), .rxd(rxd), .txd(txd_d), .irq(irq_d));

  initial clk = 1'b0;
  always #(P/2) clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_con(input logic busy);
    return {25'd0, m_fe, m_ovr, busy, m_rxdone, m_txdone, m_rx_ie, m_tx_ie};
  endfunction

  task automatic con_clear();
    m_txdone = 0; m_rxdone = 0; m_ovr = 0; m_fe = 0;
  endtask

  task automatic rx_model(input logic [7:0] b, input logic stop);
    if (stop) begin
      m_ovr = m_ovr | m_rxdone;
      m_rxdone = 1;
      m_rxd = b;
    end else m_fe = 1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    addr = a; wdata = v; wr = 1;
    @(negedge clk);
    wr = 0; addr = 0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] v);
    @(negedge clk);
    addr = a; rd = 1;
    #1 v = rdata;
    @(negedge clk);
    rd = 0; addr = 0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd = 0;
    #(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(BIT);
    end
    rxd = stop;
    #(BIT);
    rxd = 1;
  endtask

  // sends one byte, checks the serial waveform every cycle and, when probing, busy/done/irq around the frame
  task automatic run_tx(input logic [7:0] b, input logic probe, input logic [7:0] junk);
    logic e;
    logic [31:0] v;
    int idle_bad;
    bus_wr(A_TXD, {24'd0, b});
    for (int c = 0; c <= 10 * CPB; c++) begin
      e = (c < CPB) ? 1'b0 : (c < 9 * CPB) ? b[c / CPB - 1] : 1'b1;
      chk($sformatf("txd c=%0d", c), txd, e);
      rd = 0; wr = 0; addr = 0;
      if (c == 20) begin
        wr = 1; addr = A_TXD; wdata = {24'd0, junk};
      end
      if (probe && (c == 40 || c == 10 * CPB - 1 || c == 10 * CPB)) begin
        if (c == 10 * CPB) chk("irq_before_rise", irq, 0);
        rd = 1; addr = A_CON;
        #1 v = rdata;
        chk($sformatf("con c=%0d", c), v, exp_con(c < 10 * CPB));
        con_clear();
      end
      if (probe && c == 41) begin
        rd = 1; addr = A_TXD;
        #1 v = rdata;
        chk("txd_reg_busy_write", v, {24'd0, b});
      end
      if (c == 10 * CPB - 1) m_txdone = 1;
      @(negedge clk);
    end
    rd = 0; wr = 0; addr = 0;
    if (probe) begin
      chk("irq_rise", irq, 1);
      @(negedge clk);
      chk("irq_fall", irq, 0);
      idle_bad = 0;
      repeat (2 * CPB) begin
        @(negedge clk);
        if (txd !== 1'b1) idle_bad++;
      end
      chk("tx_single_frame", idle_bad, 0);
    end
  endtask

  initial begin
    rst = 1; rd = 0; wr = 0; addr = 0; wdata = 0; rxd = 1;
    m_tx_ie = 0; m_rx_ie = 0; m_rxd = 0;
    con_clear();
    repeat (3) @(negedge clk);
    chk("txd_in_reset", txd, 1);
    rst = 0;
    @(negedge clk);
    chk("reset_txd", txd, 1);
    chk("reset_irq", irq, 0);
    chk("reset_txd_def", txd_d, 1);
    chk("reset_irq_def", irq_d, 0);
    addr = A_CON; rd = 1;
    #1;
    chk("reset_con", rdata, 0);
    chk("reset_con_def", rdata_d, 0);
    @(negedge clk);
    rd = 0; addr = 0;
    bus_rd(A_RXD, d); chk("reset_rxd", d, 0);
    bus_rd(A_TXD, d); chk("reset_txdreg", d, 0);
    bus_rd(BASE + 12, d); chk("unmapped_read", d, 0);

    bus_wr(A_CON, 32'h1); m_tx_ie = 1;
    run_tx(8'h69, 1, 8'h46);
    bus_rd(A_TXD, d); chk("txd_reg_after", d, 32'h69);
    repeat (2) run_tx(8'($urandom), 1, 8'($urandom));

    bus_wr(A_CON, 32'h0); m_tx_ie = 0;
    @(negedge clk); #3;
    send_frame(8'h96, 1); rx_model(8'h96, 1);
    bus_rd(A_CON, d); chk("con_after_96", d, exp_con(0)); con_clear();
    bus_rd(A_RXD, d); chk("rxd_96", d, {24'd0, m_rxd});
    bus_rd(A_CON, d); chk("con_cleared", d, exp_con(0));
    bus_wr(A_CON, 32'h2); m_rx_ie = 1;
    @(negedge clk); #3;
    fork
      send_frame(8'hB9, 1);
      begin
        n = 0;
        while (irq !== 1'b1 && n < 400) begin
          @(posedge clk); #1; n++;
        end
      end
    join
    chk($sformatf("rx_irq_latency n=%0d", n), (n >= 9 * CPB && n <= 3 + CPB / 2 + 9 * CPB), 1);
    rx_model(8'hB9, 1);
    bus_rd(A_RXD, d); chk("rxd_b9", d, {24'd0, m_rxd});
    bus_rd(A_CON, d); chk("con_after_b9", d, exp_con(0)); con_clear();

    b0 = 8'($urandom); b1 = 8'($urandom);
    @(negedge clk); #3;
    send_frame(b0, 1); rx_model(b0, 1);
    send_frame(b1, 0); rx_model(b1, 0);
    bus_rd(A_RXD, d); chk("rxd_kept_after_fe", d, {24'd0, m_rxd});
    chk("irq_rx_pending", irq, 1);
    send_frame(8'h1E, 1); rx_model(8'h1E, 1);
    bus_rd(A_RXD, d); chk("rxd_1e_ovr", d, {24'd0, m_rxd});
    bus_rd(A_CON, d); chk("con_fe_ovr", d, exp_con(0)); con_clear();
    bus_rd(A_CON, d); chk("con_fe_ovr_cleared", d, exp_con(0));

    for (int i = 0; i < 3; i++) begin
      b2 = 8'($urandom);
      @(negedge clk); #3;
      send_frame(b2, 1); rx_model(b2, 1);
      bus_rd(A_RXD, d); chk($sformatf("rxd_rand%0d", i), d, {24'd0, m_rxd});
      bus_rd(A_CON, d); chk($sformatf("con_rand%0d", i), d, exp_con(0)); con_clear();
    end

    @(negedge clk); rxd = 0;
    repeat (2) @(negedge clk);
    rxd = 1;
    repeat (3 * CPB) @(negedge clk);
    bus_rd(A_CON, d); chk("glitch_rejected", d, exp_con(0));
    bus_rd(A_RXD, d); chk("glitch_rxd", d, {24'd0, m_rxd});

    bus_wr(A_CON, 32'h1); m_tx_ie = 1; m_rx_ie = 0;
    b0 = 8'($urandom); b1 = 8'($urandom);
    fork
      run_tx(b0, 0, 8'($urandom));
      begin
        @(negedge clk); #3;
        send_frame(b1, 1);
      end
    join
    rx_model(b1, 1);
    bus_rd(A_CON, d); chk("duplex_con", d, exp_con(0)); con_clear();
    bus_rd(A_RXD, d); chk("duplex_rxd", d, {24'd0, m_rxd});
    bus_rd(A_TXD, d); chk("duplex_txd_reg", d, {24'd0, b0});

    fork
      begin
        @(negedge clk); #3;
        send_frame(8'($urandom), 1);
      end
      begin
        bus_wr(A_TXD, {24'd0, 8'($urandom)});
        repeat (CPB / 2) @(negedge clk);
        chk("txd_start_bit", txd, 0);
        #3 rst = 1;
        #1;
        chk("txd_async_reset", txd, 1);
        chk("irq_async_reset", irq, 0);
      end
    join
    @(negedge clk); rst = 0;
    m_tx_ie = 0; m_rx_ie = 0; m_rxd = 0; con_clear();
    bus_rd(A_CON, d); chk("con_after_reset", d, exp_con(0));
    bus_rd(A_RXD, d); chk("rxd_after_reset", d, 0);
    bus_rd(A_TXD, d); chk("txdreg_after_reset", d, 0);
    @(negedge clk); #3;
    send_frame(8'h1E, 1); rx_model(8'h1E, 1);
    bus_rd(A_RXD, d); chk("rxd_1e_post_reset", d, {24'd0, m_rxd});
    bus_rd(A_CON, d); chk("con_1e_post_reset", d, exp_con(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
